// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  function automatic int calc_clkcount(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_core_baud_tick.sv
// Bit-period counter: wraps at clkcount-1 and emits a one-cycle tick there.
module uart_baud_tick #(
  parameter int clkcount = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(clkcount * 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(clkcount - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int parity_en  = 0,
  parameter int parity_odd = 0,
  parameter int stop_bits  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       donetx
);

  localparam int clkcount = calc_clkcount(clk_freq, baud_rate);
  localparam logic PAR_ODD = (parity_odd != 0);
  localparam logic [2:0] LAST_STOP = 3'(stop_bits - 1);

  uart_tx_state_t state;
  logic [7:0]     shift;
  logic           par;
  logic [2:0]     bitidx;
  logic           tick;
  logic           baud_clr;

  // Counter sits at 0 while idle so the start bit gets a full period.
  assign baud_clr = (state == IDLE);

  uart_baud_tick #(.clkcount(clkcount)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clr),
    .tick  (tick)
  );

  // tx is registered and updated on the same edge as the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shift  <= '0;
      par    <= 1'b0;
      bitidx <= '0;
      tx     <= 1'b1;
      ready  <= 1'b1;
      busy   <= 1'b0;
      donetx <= 1'b0;
    end else begin
      donetx <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (newd && ready) begin
            shift  <= tx_data;
            par    <= (^tx_data) ^ PAR_ODD;
            bitidx <= '0;
            state  <= START;
            tx     <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        START: if (tick) begin
          state <= DATA;
          tx    <= shift[0];
        end
        DATA: if (tick) begin
          if (bitidx == 3'd7) begin
            bitidx <= '0;
            if (parity_en != 0) begin
              state <= PARITY;
              tx    <= par;
            end else begin
              state <= STOP;
              tx    <= 1'b1;
            end
          end else begin
            shift  <= {1'b0, shift[7:1]};
            tx     <= shift[1];
            bitidx <= bitidx + 3'd1;
          end
        end
        PARITY: if (tick) begin
          state <= STOP;
          tx    <= 1'b1;
        end
        // bitidx is reused to count stop-bit periods.
        STOP: if (tick) begin
          if (bitidx == LAST_STOP) begin
            state  <= IDLE;
            bitidx <= '0;
            donetx <= 1'b1;
            busy   <= 1'b0;
            ready  <= 1'b1;
          end else begin
            bitidx <= bitidx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: four parameterisations checked against a frame-level line model.
module tb_uart_tx_core;

  localparam int C = 104;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] newd;
  logic [7:0] txd [4];
  logic [3:0] rdy, txv, bsy, dn;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx_core u0 (.clk(clk), .rst(rst), .newd(newd[0]), .tx_data(txd[0]),
                   .ready(rdy[0]), .tx(txv[0]), .busy(bsy[0]), .donetx(dn[0]));
  uart_tx_core #(.parity_en(1), .parity_odd(0)) u1 (.clk(clk), .rst(rst), .newd(newd[1]),
                   .tx_data(txd[1]), .ready(rdy[1]), .tx(txv[1]), .busy(bsy[1]), .donetx(dn[1]));
  uart_tx_core #(.parity_en(1), .parity_odd(1)) u2 (.clk(clk), .rst(rst), .newd(newd[2]),
                   .tx_data(txd[2]), .ready(rdy[2]), .tx(txv[2]), .busy(bsy[2]), .donetx(dn[2]));
  uart_tx_core #(.stop_bits(2)) u3 (.clk(clk), .rst(rst), .newd(newd[3]), .tx_data(txd[3]),
                   .ready(rdy[3]), .tx(txv[3]), .busy(bsy[3]), .donetx(dn[3]));

  function automatic int pe(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic int po(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int ns(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int i, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      chk("idle_tx", txv[i], 1);
      chk("idle_ready", rdy[i], 1);
      chk("idle_busy", bsy[i], 0);
      chk("idle_donetx", dn[i], 0);
      step();
    end
  endtask

  // Sends byte b on instance i and checks every line cycle against the expected frame.
  // inj >= 0: pulse newd with 0x3C at that frame cycle. abort >= 0: pulse rst there.
  task automatic frame(input int i, input logic [7:0] b, input bit keep,
                       input int inj, input int abort);
    logic bits [12];
    logic samp [12];
    logic [7:0] dec;
    int n;
    n = 9 + pe(i) + ns(i);
    bits[0] = 1'b0;
    for (int d = 0; d < 8; d++) bits[1+d] = b[d];
    if (pe(i) != 0) bits[9] = ($countones(b) % 2 == 1) ^ (po(i) != 0);
    for (int s = 0; s < ns(i); s++) bits[9 + pe(i) + s] = 1'b1;

    chk("ready_before_accept", rdy[i], 1);
    txd[i] = b;
    newd[i] = 1'b1;
    step();
    if (!keep) newd[i] = 1'b0;

    for (int p = 0; p < n * C; p++) begin
      int k;
      int j;
      k = p / C;
      j = p % C;
      if (p == abort) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_tx", txv[i], 1);
        chk("abort_ready", rdy[i], 1);
        chk("abort_busy", bsy[i], 0);
        chk("abort_donetx", dn[i], 0);
        step();
        chk("abort_donetx_late", dn[i], 0);
        return;
      end
      if (p == inj) begin
        newd[i] = 1'b1;
        txd[i] = 8'h3C;
      end
      if (p == inj + 1) newd[i] = keep;
      chk("frame_tx", txv[i], bits[k]);
      chk("frame_busy", bsy[i], 1);
      chk("frame_ready", rdy[i], 0);
      chk("frame_donetx", dn[i], 0);
      if (j == C / 2) samp[k] = txv[i];
      step();
    end

    chk("done_pulse", dn[i], 1);
    chk("done_ready", rdy[i], 1);
    chk("done_busy", bsy[i], 0);
    chk("done_tx", txv[i], 1);

    for (int d = 0; d < 8; d++) dec[d] = samp[1+d];
    chk("decoded_start", samp[0], 0);
    chk("decoded_byte", dec, b);
    if (pe(i) != 0)
      chk("decoded_parity", samp[9], ((($countones(dec) + (po(i) != 0 ? 1 : 0)) % 2) == 1));
    for (int s = 0; s < ns(i); s++) chk("decoded_stop", samp[9 + pe(i) + s], 1);
  endtask

  initial begin
    rst = 1'b1;
    newd = '0;
    for (int i = 0; i < 4; i++) txd[i] = 8'h00;
    repeat (3) step();
    // newd together with rst: reset wins.
    newd[0] = 1'b1;
    txd[0] = 8'hE7;
    step();
    newd[0] = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("reset_tx", txv[i], 1);
      chk("reset_ready", rdy[i], 1);
      chk("reset_busy", bsy[i], 0);
      chk("reset_donetx", dn[i], 0);
    end
    step();
    idle_check(0, 2);

    frame(0, 8'h55, 1'b0, -1, -1);
    step();
    idle_check(0, 3);

    frame(1, 8'hA5, 1'b0, -1, -1);
    step();
    idle_check(1, 2);
    frame(2, 8'hA5, 1'b0, -1, -1);
    step();
    idle_check(2, 2);
    frame(3, 8'hFF, 1'b0, -1, -1);
    step();
    idle_check(3, 2);

    frame(0, 8'h81, 1'b0, 300, -1);
    step();
    idle_check(0, 3);

    frame(0, 8'hC3, 1'b0, -1, 4 * C + 50);
    idle_check(0, 2);
    frame(0, 8'h0F, 1'b0, -1, -1);
    step();
    idle_check(0, 2);

    frame(0, 8'h12, 1'b1, -1, -1);
    frame(0, 8'h34, 1'b0, -1, -1);
    step();
    idle_check(0, 2);

    for (int r = 0; r < 6; r++) begin
      int i;
      logic [7:0] b;
      i = int'($urandom_range(0, 3));
      b = 8'($urandom);
      frame(i, b, 1'b0, -1, -1);
      step();
      idle_check(i, 1 + int'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

UART transmitter that serialises one byte per frame onto `tx`: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. It is the transmit end of the team's UART link, clocked directly from the system clock. Bit timing comes from an internal cycle counter, not a derived clock. Bytes are accepted through a valid/ready handshake from the host logic.

## Interface
- `clk_freq`, 1000000: system clock frequency in Hz.
- `baud_rate`, 9600: line rate in bit/s; `clkcount = clk_freq/baud_rate` (integer division) clk cycles per bit; must be ≥ 2.
- `parity_en`, 0: 1 inserts a parity bit after data bit 7.
- `parity_odd`, 0: 0 gives even parity, 1 gives odd; ignored when `parity_en=0`.
- `stop_bits`, 1: number of stop bits; legal values 1 or 2.

- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `newd`  in  1  host byte valid.
- `tx_data`  in  8  byte to send; sampled on accept.
- `ready`  out  1  high in IDLE; a byte is accepted on a cycle with `newd && ready`.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high from the cycle after accept until `donetx`.
- `donetx`  out  1  single-cycle pulse when the frame completes.

## Operation
- Reset values (cycle after `rst` is sampled high): `tx=1`, `ready=1`, `busy=0`, `donetx=0`, state IDLE, counters 0, shift register 0.
- States: IDLE → START → DATA → PARITY (only if `parity_en`) → STOP → IDLE.
- IDLE: `tx=1`. On `newd && ready`: latch `tx_data` into the shift register, compute parity (XOR of the 8 bits, inverted if `parity_odd`), go to START. `ready` and `busy` update on the same edge.
- START: `tx=0` for `clkcount` cycles.
- DATA: drive `tx=shift[0]` and shift right once every `clkcount` cycles. Bit index counts 0..7; move on after bit 7 completes.
- PARITY: `tx=parity bit` for `clkcount` cycles.
- STOP: `tx=1` for `stop_bits*clkcount` cycles, then go to IDLE. On that same edge: `donetx=1`, `busy=0`, `ready=1`.
- Baud counter: counts 0..`clkcount-1`, resets to 0 on every state or bit change, and is held at 0 in IDLE. Width is `$clog2(clkcount*2)`.
- `newd` while `ready=0` is ignored. No buffering. `tx_data` changes mid-frame have no effect.
- `rst` mid-frame: the frame aborts, and the next edge sees `tx=1` and IDLE. `donetx` does not pulse.
- `newd` and `rst` together: reset wins and nothing is accepted.
- `newd` held high continuously: a new byte is accepted on the `donetx` cycle (`ready` is already 1). Back-to-back frames therefore have zero idle bit time, with the next start bit beginning one clk after `donetx`.

## Timing
- Accept edge at T. `tx` falls at T+1 (registered output).
- Frame bits N = 1 + 8 + `parity_en` + `stop_bits`.
- Bit k (0 = start) occupies cycles T+1+k·clkcount through T+(k+1)·clkcount.
- `donetx` is high for exactly cycle T+1+N·clkcount−… Defined precisely: `donetx` is high in the single cycle after the last stop-bit cycle, i.e. at T+1+N·clkcount.
- Defaults (clkcount=104, N=10): `donetx` at T+1041.
- `tx`, `ready`, `busy` and `donetx` are all registered; there are no combinational paths from inputs to outputs.

## Structure
- `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t`.
  - Function `calc_clkcount(clk_freq, baud_rate)`.
  - Shared by transmit and receive.
- Sub-module `uart_baud_tick`: the cycle counter with synchronous clear. It outputs a one-cycle `tick` when the count reaches `clkcount-1`. The top-level FSM uses `tick` to advance.

## Test plan
- Defaults, send 0x55 → `tx` pattern 0,1,0,1,0,1,0,1,0,1 with each level held 104 cycles. `donetx` is a single pulse at T+1041 and `ready` rises in the same cycle.
- `parity_en=1`, even, send 0xA5 → parity bit 0. With `parity_odd=1` → parity bit 1. Frame is 11 bits and `donetx` is at T+1145.
- `stop_bits=2`, send 0xFF → start bit 0, then `tx` high for 10·104 cycles. `busy` stays high until `donetx`.
- `newd` pulsed mid-frame with 0x3C while sending 0x81 → 0x3C never appears on `tx`. `ready` stays 0 and only one `donetx` pulse occurs.
- Assert `rst` for 1 cycle during DATA bit 3 → `tx=1`, `ready=1`, `busy=0` on the next cycle. No `donetx`. The next byte (0x0F) is transmitted correctly.
- `newd` held high with 0x12 then 0x34 → two frames back-to-back, second start bit at `donetx`+1. A bench decoder recovers 0x12 then 0x34.
